// File: rtl/serial_hub_pkg.sv
// Shared constants and helpers for the cluster serial hub.
// Link timing defaults assume 50 MHz system clock and 115200 baud.
package serial_hub_pkg;

   localparam int unsigned NONCE_BYTES            = 4;
   localparam int unsigned CLK_HZ                 = 50_000_000;
   localparam int unsigned BAUD                   = 115_200;
   localparam int unsigned CYCLES_PER_BYTE        = CLK_HZ / BAUD * 10;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 20_000;

   // What the receive slot does with the current cycle's input.
   typedef enum logic [1:0] {
      EV_NONE,
      EV_WORD,
      EV_OVERFLOW,
      EV_TIMEOUT
   } rx_event_e;

   function automatic int unsigned byte_lane(
      input int unsigned idx,
      input int unsigned nbytes,
      input bit          msb_first
   );
      return msb_first ? (nbytes - 1 - idx) : idx;
   endfunction

endpackage

// File: rtl/serial_word_receiver_timer.sv
// Inter-byte idle timer; expiry is flagged on the edge the silent-cycle
// count would reach TIMEOUT_CYCLES, so a byte on that edge pre-empts it.
module rx_idle_timer
   import serial_hub_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam bit          ARMED = (TIMEOUT_CYCLES != 0);
   localparam int unsigned CW    = ARMED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT =
      CW'(ARMED ? TIMEOUT_CYCLES - 1 : 0);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit;

   assign hit     = ARMED && enable && !clear && (cnt_q == LIMIT);
   assign expired = hit;

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || !enable || hit || !ARMED) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/serial_word_receiver.sv
// Assembles BYTES-wide words from a byte stream into a valid/ready slot,
// with overflow reporting and idle-timeout resynchronisation.
module serial_word_receiver
   import serial_hub_pkg::*;
#(
   parameter int unsigned BYTES          = NONCE_BYTES,
   parameter bit          MSB_FIRST      = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [7:0]                   rx_byte,
   input  logic                         rx_byte_valid,
   output logic [8*BYTES-1:0]           word,
   output logic                         word_valid,
   input  logic                         word_ready,
   output logic                         overflow,
   output logic                         timeout,
   output logic [$clog2(BYTES+1)-1:0]   bytes_pending
);

   localparam int unsigned   PW   = $clog2(BYTES + 1);
   localparam int unsigned   WW   = 8 * BYTES;
   localparam logic [PW-1:0] LAST = PW'(BYTES - 1);

   logic [WW-1:0] part_q, part_d;
   logic [WW-1:0] word_q, word_d;
   logic          word_valid_q, word_valid_d;
   logic          overflow_q, overflow_d;
   logic          timeout_q, timeout_d;
   logic [PW-1:0] cnt_q, cnt_d;

   logic [WW-1:0] asm_w;
   logic          last_byte;
   logic          slot_free;
   logic          idle_clear;
   logic          idle_en;
   logic          idle_expired;
   rx_event_e     ev;

   // Partial word with the incoming byte dropped into its lane.
   always_comb begin
      asm_w = part_q;
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (cnt_q == PW'(i)) begin
            asm_w[8*byte_lane(i, BYTES, MSB_FIRST) +: 8] = rx_byte;
         end
      end
   end

   assign last_byte  = rx_byte_valid && (cnt_q == LAST);
   assign slot_free  = !word_valid_q || word_ready;
   assign idle_en    = (cnt_q != '0);
   assign idle_clear = rx_byte_valid || (cnt_q == '0);

   rx_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle (
      .clk     (clk),
      .reset   (reset),
      .clear   (idle_clear),
      .enable  (idle_en),
      .expired (idle_expired)
   );

   always_comb begin
      ev = EV_NONE;
      if (last_byte) begin
         ev = slot_free ? EV_WORD : EV_OVERFLOW;
      end else if (idle_expired) begin
         ev = EV_TIMEOUT;
      end
   end

   always_comb begin
      part_d       = part_q;
      cnt_d        = cnt_q;
      word_d       = word_q;
      word_valid_d = word_valid_q && !word_ready;
      overflow_d   = 1'b0;
      timeout_d    = 1'b0;
      if (rx_byte_valid) begin
         part_d = asm_w;
         cnt_d  = last_byte ? '0 : cnt_q + PW'(1);
      end
      unique case (ev)
         EV_WORD: begin
            word_d       = asm_w;
            word_valid_d = 1'b1;
         end
         EV_OVERFLOW: overflow_d = 1'b1;
         EV_TIMEOUT: begin
            cnt_d     = '0;
            timeout_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         part_q       <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         timeout_q    <= 1'b0;
         cnt_q        <= '0;
      end else begin
         part_q       <= part_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         overflow_q   <= overflow_d;
         timeout_q    <= timeout_d;
         cnt_q        <= cnt_d;
      end
   end

   assign word          = word_q;
   assign word_valid    = word_valid_q;
   assign overflow      = overflow_q;
   assign timeout       = timeout_q;
   assign bytes_pending = cnt_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: three parameterisations fed the same
// byte stream, checked against directed constants and a queue-level model.
module tb_serial_word_receiver;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid;
   logic        word_ready;

   logic [31:0] w_a, w_b;
   logic [7:0]  w_c;
   logic        v_a, v_b, v_c;
   logic        o_a, o_b, o_c;
   logic        t_a, t_b, t_c;
   logic [2:0]  p_a, p_b;
   logic        p_c;

   int total = 0;
   int bad   = 0;

   logic [7:0]  mbuf  [3][4];
   int          mcnt  [3];
   int          midle [3];
   logic [31:0] mword [3];
   logic        mvalid[3];
   logic        movf  [3];
   logic        mtmo  [3];

   always #5 clk = ~clk;

   serial_word_receiver #(.BYTES(4), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) dut_a (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
      .word(w_a), .word_valid(v_a), .word_ready(word_ready),
      .overflow(o_a), .timeout(t_a), .bytes_pending(p_a));

   serial_word_receiver #(.BYTES(4), .MSB_FIRST(1'b0), .TIMEOUT_CYCLES(TO)) dut_b (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
      .word(w_b), .word_valid(v_b), .word_ready(word_ready),
      .overflow(o_b), .timeout(t_b), .bytes_pending(p_b));

   serial_word_receiver #(.BYTES(1), .MSB_FIRST(1'b1), .TIMEOUT_CYCLES(TO)) dut_c (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
      .word(w_c), .word_valid(v_c), .word_ready(word_ready),
      .overflow(o_c), .timeout(t_c), .bytes_pending(p_c));

   function automatic int nb(input int i);
      return (i == 2) ? 1 : 4;
   endfunction

   function automatic bit mf(input int i);
      return (i == 1) ? 1'b0 : 1'b1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mcnt[i]   = 0;
         midle[i]  = 0;
         mword[i]  = '0;
         mvalid[i] = 1'b0;
         movf[i]   = 1'b0;
         mtmo[i]   = 1'b0;
      end
   endtask

   // Word-level behaviour: collect bytes, place by arrival order, then
   // either fill the slot or drop the word; silence of TO cycles drops bytes.
   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         bit          free;
         logic [31:0] w;
         free    = !mvalid[i] || word_ready;
         movf[i] = 1'b0;
         mtmo[i] = 1'b0;
         if (mvalid[i] && word_ready) mvalid[i] = 1'b0;
         if (rx_byte_valid) begin
            mbuf[i][mcnt[i]] = rx_byte;
            mcnt[i]++;
            midle[i] = 0;
            if (mcnt[i] == nb(i)) begin
               w = '0;
               for (int k = 0; k < nb(i); k++) begin
                  w |= 32'(mbuf[i][k]) << (8 * (mf(i) ? nb(i) - 1 - k : k));
               end
               mcnt[i] = 0;
               if (free) begin
                  mword[i]  = w;
                  mvalid[i] = 1'b1;
               end else begin
                  movf[i] = 1'b1;
               end
            end
         end else if (mcnt[i] > 0) begin
            midle[i]++;
            if (midle[i] == TO) begin
               mcnt[i]  = 0;
               midle[i] = 0;
               mtmo[i]  = 1'b1;
            end
         end else begin
            midle[i] = 0;
         end
      end
   endtask

   task automatic tick(input logic [7:0] b, input logic v, input logic r);
      rx_byte       = b;
      rx_byte_valid = v;
      word_ready    = r;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic send4(input logic [31:0] w, input logic r);
      logic [31:0] t;
      t = w;
      for (int k = 0; k < 4; k++) begin
         tick(t[31-8*k -: 8], 1'b1, r);
      end
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      rx_byte       = 8'h00;
      rx_byte_valid = 1'b0;
      word_ready    = 1'b0;
      model_reset();
      #2;
      total++; if (w_a !== 32'h0) begin bad++; $display("FAIL rst_word got=%h want=0", w_a); end
      total++; if (v_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", v_a); end
      total++; if (o_a !== 1'b0 || t_a !== 1'b0) begin bad++; $display("FAIL rst_pulses got=%b%b want=00", o_a, t_a); end
      total++; if (p_a !== 3'd0) begin bad++; $display("FAIL rst_pending got=%0d want=0", p_a); end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_byte_order();
      logic [7:0] bs [4];
      bs = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      for (int k = 0; k < 4; k++) begin
         tick(bs[k], 1'b1, 1'b1);
         total++;
         if (p_a !== 3'((k + 1) % 4)) begin
            bad++; $display("FAIL order_pending k=%0d got=%0d want=%0d", k, p_a, (k + 1) % 4);
         end
         if (k < 3) begin
            total++; if (v_a !== 1'b0) begin bad++; $display("FAIL order_early_valid k=%0d got=%b want=0", k, v_a); end
            for (int g = 0; g < 9; g++) tick(8'h00, 1'b0, 1'b1);
         end
      end
      total++; if (v_a !== 1'b1) begin bad++; $display("FAIL order_valid got=%b want=1", v_a); end
      total++; if (w_a !== 32'hDEADBEEF) begin bad++; $display("FAIL order_msb got=%h want=deadbeef", w_a); end
      total++; if (w_b !== 32'hEFBEADDE) begin bad++; $display("FAIL order_lsb got=%h want=efbeadde", w_b); end
      total++; if (w_c !== 8'hEF || p_c !== 1'b0) begin bad++; $display("FAIL order_b1 got=%h/%b want=ef/0", w_c, p_c); end
      tick(8'h00, 1'b0, 1'b1);
      total++; if (v_a !== 1'b0) begin bad++; $display("FAIL order_one_cycle got=%b want=0", v_a); end
   endtask

   task automatic test_overflow();
      send4(32'h11223344, 1'b0);
      total++; if (v_a !== 1'b1 || w_a !== 32'h11223344) begin bad++; $display("FAIL ovf_first got=%b/%h want=1/11223344", v_a, w_a); end
      tick(8'h55, 1'b1, 1'b0);
      tick(8'h66, 1'b1, 1'b0);
      tick(8'h77, 1'b1, 1'b0);
      total++; if (o_a !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", o_a); end
      tick(8'h88, 1'b1, 1'b0);
      total++; if (o_a !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b want=1", o_a); end
      total++; if (w_a !== 32'h11223344 || v_a !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%b/%h want=1/11223344", v_a, w_a); end
      tick(8'h00, 1'b0, 1'b0);
      total++; if (o_a !== 1'b0) begin bad++; $display("FAIL ovf_width got=%b want=0", o_a); end
      tick(8'h00, 1'b0, 1'b1);
      total++; if (v_a !== 1'b0) begin bad++; $display("FAIL ovf_consume got=%b want=0", v_a); end
      for (int g = 0; g < 3; g++) tick(8'h00, 1'b0, 1'b0);
      total++; if (v_a !== 1'b0) begin bad++; $display("FAIL ovf_no_second got=%b want=0", v_a); end
   endtask

   task automatic test_back_to_back();
      send4(32'h11223344, 1'b0);
      tick(8'hAA, 1'b1, 1'b0);
      tick(8'hBB, 1'b1, 1'b0);
      tick(8'hCC, 1'b1, 1'b0);
      total++; if (w_a !== 32'h11223344) begin bad++; $display("FAIL b2b_stable got=%h want=11223344", w_a); end
      tick(8'hDD, 1'b1, 1'b1);
      total++; if (w_a !== 32'hAABBCCDD || v_a !== 1'b1) begin bad++; $display("FAIL b2b_refill got=%b/%h want=1/aabbccdd", v_a, w_a); end
      total++; if (o_a !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b want=0", o_a); end
      tick(8'h00, 1'b0, 1'b1);
      total++; if (v_a !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", v_a); end
   endtask

   task automatic test_timeout();
      int early;
      early = 0;
      tick(8'h01, 1'b1, 1'b1);
      tick(8'h02, 1'b1, 1'b1);
      for (int g = 1; g < TO; g++) begin
         tick(8'h00, 1'b0, 1'b1);
         if (t_a !== 1'b0 || p_a !== 3'd2) early++;
      end
      total++; if (early != 0) begin bad++; $display("FAIL tmo_early got=%0d want=0", early); end
      tick(8'h00, 1'b0, 1'b1);
      total++; if (t_a !== 1'b1 || p_a !== 3'd0) begin bad++; $display("FAIL tmo_fire got=%b/%0d want=1/0", t_a, p_a); end
      tick(8'h00, 1'b0, 1'b1);
      total++; if (t_a !== 1'b0) begin bad++; $display("FAIL tmo_width got=%b want=0", t_a); end
      send4(32'hCAFEF00D, 1'b1);
      total++; if (w_a !== 32'hCAFEF00D || v_a !== 1'b1) begin bad++; $display("FAIL tmo_clean got=%b/%h want=1/cafef00d", v_a, w_a); end
      tick(8'h01, 1'b1, 1'b1);
      tick(8'h02, 1'b1, 1'b1);
      for (int g = 1; g < TO; g++) tick(8'h00, 1'b0, 1'b1);
      tick(8'h03, 1'b1, 1'b1);
      total++; if (t_a !== 1'b0 || p_a !== 3'd3) begin bad++; $display("FAIL tmo_byte_wins got=%b/%0d want=0/3", t_a, p_a); end
      tick(8'h04, 1'b1, 1'b1);
      total++; if (w_a !== 32'h01020304) begin bad++; $display("FAIL tmo_resume got=%h want=01020304", w_a); end
   endtask

   task automatic test_reset_async();
      send4(32'h12345678, 1'b0);
      tick(8'h9A, 1'b1, 1'b0);
      tick(8'hBC, 1'b1, 1'b0);
      total++; if (v_a !== 1'b1 || p_a !== 3'd2) begin bad++; $display("FAIL arst_setup got=%b/%0d want=1/2", v_a, p_a); end
      rx_byte_valid = 1'b0;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      total++; if (w_a !== 32'h0 || v_a !== 1'b0 || p_a !== 3'd0) begin bad++; $display("FAIL arst_clear got=%h/%b/%0d want=0/0/0", w_a, v_a, p_a); end
      total++; if (o_a !== 1'b0 || t_a !== 1'b0 || w_b !== 32'h0) begin bad++; $display("FAIL arst_other got=%b%b/%h want=00/0", o_a, t_a, w_b); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      send4(32'h0F1E2D3C, 1'b1);
      total++; if (w_a !== 32'h0F1E2D3C || v_a !== 1'b1) begin bad++; $display("FAIL arst_after got=%b/%h want=1/0f1e2d3c", v_a, w_a); end
      total++; if (o_a !== 1'b0) begin bad++; $display("FAIL arst_ovf got=%b want=0", o_a); end
   endtask

   task automatic test_random();
      int p;
      reset = 1'b1;
      model_reset();
      #1;
      reset = 1'b0;
      p = 70;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) begin
            case ($urandom_range(0, 2))
               0:       p = 70;
               1:       p = 25;
               default: p = 4;
            endcase
         end
         tick(8'($urandom), ($urandom_range(0, 99) < p), ($urandom_range(0, 1) == 1));
         for (int i = 0; i < 3; i++) begin
            logic [31:0] gw;
            logic        gv, go, gt;
            int          gp;
            case (i)
               0: begin gw = w_a; gv = v_a; go = o_a; gt = t_a; gp = int'(p_a); end
               1: begin gw = w_b; gv = v_b; go = o_b; gt = t_b; gp = int'(p_b); end
               default: begin gw = {24'h0, w_c}; gv = v_c; go = o_c; gt = t_c; gp = int'(p_c); end
            endcase
            total++;
            if ({gw, gv, go, gt} !== {mword[i], mvalid[i], movf[i], mtmo[i]} || gp != mcnt[i]) begin
               bad++;
               $display("FAIL rand inst=%0d cyc=%0d got w=%h v=%b o=%b t=%b p=%0d want w=%h v=%b o=%b t=%b p=%0d",
                        i, c, gw, gv, go, gt, gp, mword[i], mvalid[i], movf[i], mtmo[i], mcnt[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte_order();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_reset_async();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
